change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001: Parameter WIDTH, default 8: bit width of the change amount and the remaining amount.
REQ-002: Parameter D_BIG, default 10: large coin value in units; SHALL satisfy D_BIG > D_MID.
REQ-003: Parameter D_MID, default 5: medium coin value; SHALL satisfy D_MID > D_SMALL.
REQ-004: Parameter D_SMALL, default 1: small coin value; SHALL satisfy D_SMALL >= 1.
REQ-005: clk  input  1  single clock; all state changes on its rising edge.
REQ-006: rst_n  input  1  synchronous, active-low reset.
REQ-007: start  input  1  request to dispense change; sampled only in IDLE.
REQ-008: amount  input  WIDTH  change value in units; captured when start is accepted.
REQ-009: empty_big / empty_mid / empty_small  input  1 each  hopper-empty flags, sampled in SELECT.
REQ-010: coin_valid  output  1  a coin eject request is presented.
REQ-011: coin_sel  output  2  coin to eject: 00 small, 01 mid, 10 big; 11 is never driven.
REQ-012: coin_ready  input  1  ejector accepts; handshake completes when coin_valid && coin_ready.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  one-cycle pulse at the end of every accepted transaction.
REQ-015: fault  output  1  one-cycle pulse, coincident with done, when change cannot be completed.
REQ-016: remaining  output  WIDTH  undispensed value; held after done until the next accepted start.
REQ-017: coin_count  output  8  coins ejected in the current or last transaction; saturates at 255.

Function
REQ-018: FSM states SHALL be IDLE, SELECT, ISSUE and FINISH.
REQ-019: In IDLE, start=1 SHALL load remaining<=amount, clear coin_count and go to SELECT next cycle.
REQ-020: start SHALL be ignored while busy=1.
REQ-021: SELECT, remaining==0: go to FINISH, no coin issued.
REQ-022: SELECT, remaining>0: choose the largest denomination with value <= remaining whose empty flag is 0, in the order big, mid, small; register coin_sel; go to ISSUE.
REQ-023: SELECT with no eligible denomination SHALL set an internal fault flag and go to FINISH.
REQ-024: ISSUE SHALL hold coin_valid=1 with coin_sel stable until the handshake; coin_valid is 0 in all other states.
REQ-025: On handshake, remaining SHALL drop by the selected value, coin_count SHALL increment, and the FSM SHALL return to SELECT.
REQ-026: Subtraction SHALL never underflow, because the selected value is always <= remaining.
REQ-027: FINISH SHALL pulse done for exactly one cycle, pulse fault if the flag is set, then return to IDLE.
REQ-028: Latency: start with amount=0 gives done 2 cycles after the start edge; each coin costs SELECT (1 cycle) plus ISSUE (>=1 cycle).
REQ-029: Empty flags that change during ISSUE SHALL NOT affect the coin already presented.

Reset
REQ-030: rst_n=0 at a clock edge SHALL force IDLE with coin_valid=0, coin_sel=00, busy=0, done=0, fault=0, remaining=0, coin_count=0 and the fault flag cleared.
REQ-031: Reset mid-transaction SHALL abandon it immediately, with no done pulse and no coin_valid on the following cycle.

Verification
REQ-032: amount=17, all hoppers full, coin_ready=1 -> coin_sel sequence 10,01,00,00; done after the 4th coin; remaining=0; coin_count=4; fault=0.
REQ-033: amount=0 -> done 2 cycles after start; no coin_valid; fault=0; coin_count=0.
REQ-034: amount=12, empty_big=1 -> coin_sel 01,01,00,00; remaining=0.
REQ-035: amount=3, empty_small=1 -> no coins; done and fault pulse together; remaining=3.
REQ-036: amount=10, coin_ready held low 3 cycles -> coin_valid=1 and coin_sel=10 stable for 4 cycles; start pulses in that window are ignored.
REQ-037: rst_n=0 during ISSUE of amount=17 -> next cycle busy=0, coin_valid=0, remaining=0, no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy coin dispenser. On an accepted start it captures the change amount
// and ejects coins one at a time, always choosing the largest denomination
// that fits the remaining value and whose hopper is not empty. Each coin is
// offered on a valid/ready handshake. The transaction ends with a one-cycle
// done pulse, accompanied by fault when the change could not be completed.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   dispense request, only honoured in IDLE
//   amount       in   change value, captured on an accepted start
//   empty_big    in   big-coin hopper empty
//   empty_mid    in   mid-coin hopper empty
//   empty_small  in   small-coin hopper empty
//   coin_ready   in   ejector accepts the presented coin
//   coin_valid   out  coin eject request presented
//   coin_sel     out  00 small, 01 mid, 10 big
//   busy         out  high outside IDLE
//   done         out  one-cycle end-of-transaction pulse
//   fault        out  one-cycle pulse with done when change is incomplete
//   remaining    out  undispensed value, held until the next accepted start
//   coin_count   out  coins ejected in this/last transaction, saturating
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// SELECT  | pick the next denomination, or finish (done / no coin fits)
// ISSUE   | present coin_sel with coin_valid until coin_ready
// FINISH  | raise done (and fault) for one cycle, then back to IDLE
//
// Denominations must satisfy D_BIG > D_MID > D_SMALL >= 1.

module change_dispenser #(
  parameter int WIDTH   = 8,
  parameter int D_BIG   = 10,
  parameter int D_MID   = 5,
  parameter int D_SMALL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             empty_big,
  input  logic             empty_mid,
  input  logic             empty_small,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] remaining,
  output logic [7:0]       coin_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [1:0] SEL_SMALL = 2'b00;
  localparam logic [1:0] SEL_MID   = 2'b01;
  localparam logic [1:0] SEL_BIG   = 2'b10;

  localparam logic [WIDTH-1:0] V_BIG   = WIDTH'(D_BIG);
  localparam logic [WIDTH-1:0] V_MID   = WIDTH'(D_MID);
  localparam logic [WIDTH-1:0] V_SMALL = WIDTH'(D_SMALL);

  logic [1:0]       state;
  logic             fault_flag;
  logic [WIDTH-1:0] sel_value;

  // coin_sel is registered in SELECT and frozen through ISSUE, so the value
  // subtracted on the handshake is the one that was actually presented,
  // regardless of what the empty flags do meanwhile.
  always_comb begin
    sel_value = V_SMALL;
    case (coin_sel)
      SEL_BIG: sel_value = V_BIG;
      SEL_MID: sel_value = V_MID;
      default: sel_value = V_SMALL;
    endcase
  end

  assign coin_valid = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      coin_sel   <= SEL_SMALL;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_flag <= 1'b0;
      remaining  <= '0;
      coin_count <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining  <= amount;
            coin_count <= '0;
            fault_flag <= 1'b0;
            state      <= S_SELECT;
          end
        end
        S_SELECT: begin
          // Each candidate is only taken when it fits, so the later
          // subtraction in ISSUE can never wrap below zero.
          if (remaining == '0) begin
            state <= S_FINISH;
          end else if (!empty_big && remaining >= V_BIG) begin
            coin_sel <= SEL_BIG;
            state    <= S_ISSUE;
          end else if (!empty_mid && remaining >= V_MID) begin
            coin_sel <= SEL_MID;
            state    <= S_ISSUE;
          end else if (!empty_small && remaining >= V_SMALL) begin
            coin_sel <= SEL_SMALL;
            state    <= S_ISSUE;
          end else begin
            fault_flag <= 1'b1;
            state      <= S_FINISH;
          end
        end
        S_ISSUE: begin
          if (coin_ready) begin
            remaining <= remaining - sel_value;
            if (coin_count != 8'hFF) begin
              coin_count <= coin_count + 8'd1;
            end
            state <= S_SELECT;
          end
        end
        default: begin
          // done/fault are registered here, so they appear the cycle after
          // FINISH, while the FSM is already back in IDLE.
          done  <= 1'b1;
          fault <= fault_flag;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int WIDTH   = 8;
  localparam int D_BIG   = 10;
  localparam int D_MID   = 5;
  localparam int D_SMALL = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] amount;
  logic             empty_big, empty_mid, empty_small;
  logic             coin_ready;
  logic             coin_valid;
  logic [1:0]       coin_sel;
  logic             busy, done, fault;
  logic [WIDTH-1:0] remaining;
  logic [7:0]       coin_count;

  int ncmp  = 0;
  int nfail = 0;

  int exp_q[$];
  int exp_rem;
  bit exp_flt;

  change_dispenser #(
    .WIDTH(WIDTH), .D_BIG(D_BIG), .D_MID(D_MID), .D_SMALL(D_SMALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .empty_big(empty_big), .empty_mid(empty_mid), .empty_small(empty_small),
    .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .busy(busy), .done(done), .fault(fault), .remaining(remaining),
    .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Greedy change-making with the hopper flags fixed for the transaction.
  // Coin codes: 2 big, 1 mid, 0 small.
  task automatic model(input int amt, input bit eb, input bit em, input bit es);
    exp_q   = {};
    exp_rem = amt;
    exp_flt = 1'b0;
    while (exp_rem > 0) begin
      if (!eb && exp_rem >= D_BIG) begin
        exp_q.push_back(2); exp_rem -= D_BIG;
      end else if (!em && exp_rem >= D_MID) begin
        exp_q.push_back(1); exp_rem -= D_MID;
      end else if (!es && exp_rem >= D_SMALL) begin
        exp_q.push_back(0); exp_rem -= D_SMALL;
      end else begin
        exp_flt = 1'b1;
        break;
      end
    end
  endtask

  // Runs one transaction. While a coin is presented, coin_ready follows
  // ready_pct (after stall_first forced stalls) and the empty flags are
  // scrambled; start/amount are scrambled whenever the DUT is busy.
  task automatic run_txn(input string name, input int amt, input bit eb, input bit em,
                         input bit es, input int ready_pct, input int stall_first);
    int idx, stalls, cyc, forced;
    bit got_done;
    int held_rem;
    model(amt, eb, em, es);
    amount = WIDTH'(amt);
    empty_big = eb; empty_mid = em; empty_small = es;
    coin_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, " busy_after_start"}, 32'(busy), 32'd1);
    idx = 0; stalls = 0; cyc = 1; forced = 0; got_done = 1'b0;
    while (cyc < 3000 && !got_done) begin
      if (coin_valid) begin
        if (idx < exp_q.size())
          check({name, " coin_sel"}, 32'(coin_sel), 32'(exp_q[idx]));
        else
          check({name, " coin_index"}, 32'(idx), 32'(exp_q.size() - 1));
        if (forced < stall_first) begin
          coin_ready = 1'b0;
          forced++;
        end else begin
          coin_ready = ($urandom_range(99) < ready_pct);
        end
        empty_big = 1'($urandom_range(1));
        empty_mid = 1'($urandom_range(1));
        empty_small = 1'($urandom_range(1));
        if (coin_ready) idx++;
        else stalls++;
      end else begin
        coin_ready = 1'($urandom_range(1));
        empty_big = eb; empty_mid = em; empty_small = es;
      end
      if (busy) begin
        start  = 1'($urandom_range(1));
        amount = WIDTH'($urandom_range(255));
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    coin_ready = 1'b0;
    check({name, " done_seen"}, 32'(got_done), 32'd1);
    check({name, " latency"}, 32'(cyc - 1), 32'(2 + 2 * exp_q.size() + stalls));
    check({name, " coins_issued"}, 32'(idx), 32'(exp_q.size()));
    check({name, " remaining"}, 32'(remaining), 32'(exp_rem));
    check({name, " coin_count"}, 32'(coin_count), 32'(exp_q.size() > 255 ? 255 : exp_q.size()));
    check({name, " fault"}, 32'(fault), 32'(exp_flt));
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    held_rem = exp_rem;
    step();
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " fault_one_cycle"}, 32'(fault), 32'd0);
    check({name, " remaining_held"}, 32'(remaining), 32'(held_rem));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; amount = '0;
    empty_big = 1'b0; empty_mid = 1'b0; empty_small = 1'b0; coin_ready = 1'b0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset coin_valid", 32'(coin_valid), 32'd0);
    check("reset coin_sel", 32'(coin_sel), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset remaining", 32'(remaining), 32'd0);
    check("reset coin_count", 32'(coin_count), 32'd0);
    rst_n = 1'b1;
    step();

    run_txn("amt17_full", 17, 1'b0, 1'b0, 1'b0, 100, 0);
    run_txn("amt0", 0, 1'b0, 1'b0, 1'b0, 100, 0);
    run_txn("amt12_nobig", 12, 1'b1, 1'b0, 1'b0, 100, 0);
    run_txn("amt3_nosmall", 3, 1'b0, 1'b0, 1'b1, 100, 0);
    run_txn("amt10_stall3", 10, 1'b0, 1'b0, 1'b0, 100, 3);

    // Reset in the middle of issuing a coin.
    amount = 8'd17; coin_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("midreset in_issue", 32'(coin_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset coin_valid", 32'(coin_valid), 32'd0);
    check("midreset remaining", 32'(remaining), 32'd0);
    check("midreset coin_count", 32'(coin_count), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    check("midreset done_after", 32'(done), 32'd0);
    check("midreset busy_after", 32'(busy), 32'd0);

    for (int t = 0; t < 25; t++) begin
      run_txn("random", int'($urandom_range(255)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(100, 30)), int'($urandom_range(2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
